// File: rtl/scene_render_pkg.sv
// Shared colours, pipe constants and the colour priority rule for the scene renderer.
package scene_render_pkg;

    localparam logic [23:0] COL_SKY       = 24'h70C5CE;
    localparam logic [23:0] COL_PIPE      = 24'h5EBD3B;
    localparam logic [23:0] COL_GROUND    = 24'hDED895;
    localparam logic [23:0] COL_BIRD      = 24'hF8E71C;
    localparam logic [23:0] COL_BIRD_DEAD = 24'hE03020;

    localparam logic [11:0] PIPE_DISABLE = 12'hFFF;
    localparam int          NUM_PIPES    = 4;

    // Bird beats any pipe, pipes beat ground, ground beats sky.
    function automatic logic [23:0] pick_colour(input logic bird,
                                                input logic pipe,
                                                input logic ground,
                                                input logic dead);
        logic [23:0] colour;
        colour = COL_SKY;
        if (bird) begin
            colour = dead ? COL_BIRD_DEAD : COL_BIRD;
        end else if (pipe) begin
            colour = COL_PIPE;
        end else if (ground) begin
            colour = COL_GROUND;
        end
        return colour;
    endfunction

endpackage

// File: rtl/scene_render_span_hit.sv
// Tests whether a coordinate lies in [base, base+len); the upper bound is kept at
// 13 bits so a span running past 4095 is clipped instead of wrapping to column 0.
module span_hit
    import scene_render_pkg::*;
(
    input  logic [11:0] coord,
    input  logic [11:0] base,
    input  logic [11:0] len,
    output logic        hit
);

    logic [12:0] lo;
    logic [12:0] hi;
    logic [12:0] pos;

    assign pos = {1'b0, coord};
    assign lo  = {1'b0, base};
    assign hi  = lo + {1'b0, len};
    assign hit = (pos >= lo) && (pos < hi);

endmodule

// File: rtl/scene_render.sv
// Flappy-style scene renderer: per-frame shadow of the game state, then a two-stage
// pixel pipeline (hit tests, then colour) feeding the timing driver.
module scene_render
    import scene_render_pkg::*;
#(
    parameter int BIRD_X   = 200,
    parameter int BIRD_W   = 34,
    parameter int BIRD_H   = 24,
    parameter int PIPE_W   = 52,
    parameter int GAP_H    = 200,
    parameter int GROUND_Y = 800
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [11:0] Set_X,
    input  logic [11:0] Set_Y,
    input  logic        RGB_VDE,
    input  logic        RGB_VSync,
    input  logic [11:0] Bird_Y,
    input  logic [47:0] Pipe_X,
    input  logic [47:0] Gap_Y,
    input  logic        Game_Over,
    output logic [23:0] RGB_In,
    output logic        Frame_Tick,
    output logic [15:0] Frame_Cnt
);

    logic                 vsync_d;
    logic                 vsync_rise;
    logic [11:0]          s_bird_y;
    logic [47:0]          s_pipe_x;
    logic [47:0]          s_gap_y;
    logic                 s_over;
    logic [15:0]          frame_cnt;

    logic                 bird_x_hit;
    logic                 bird_y_hit;
    logic [NUM_PIPES-1:0] pipe_x_hit;
    logic [NUM_PIPES-1:0] gap_y_hit;
    logic [NUM_PIPES-1:0] pipe_hit;
    logic                 ground_hit;

    logic                 bird_q;
    logic [NUM_PIPES-1:0] pipe_q;
    logic                 ground_q;
    logic                 dead_q;
    logic                 vde_q;

    // Gated with Rst so a high VSync during reset cannot produce a tick.
    assign vsync_rise = RGB_VSync & ~vsync_d;
    assign Frame_Tick = vsync_rise & Rst;
    assign Frame_Cnt  = frame_cnt;

    // Game state is sampled once per frame so the picture never tears mid-field.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            vsync_d   <= 1'b0;
            s_bird_y  <= '0;
            s_pipe_x  <= {NUM_PIPES{PIPE_DISABLE}};
            s_gap_y   <= '0;
            s_over    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_d <= RGB_VSync;
            if (vsync_rise) begin
                s_bird_y  <= Bird_Y;
                s_pipe_x  <= Pipe_X;
                s_gap_y   <= Gap_Y;
                s_over    <= Game_Over;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    span_hit u_bird_x (
        .coord (Set_X),
        .base  (12'(BIRD_X)),
        .len   (12'(BIRD_W)),
        .hit   (bird_x_hit)
    );

    span_hit u_bird_y (
        .coord (Set_Y),
        .base  (s_bird_y),
        .len   (12'(BIRD_H)),
        .hit   (bird_y_hit)
    );

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        span_hit u_pipe_x (
            .coord (Set_X),
            .base  (s_pipe_x[12*i +: 12]),
            .len   (12'(PIPE_W)),
            .hit   (pipe_x_hit[i])
        );

        span_hit u_gap_y (
            .coord (Set_Y),
            .base  (s_gap_y[12*i +: 12]),
            .len   (12'(GAP_H)),
            .hit   (gap_y_hit[i])
        );

        assign pipe_hit[i] = (s_pipe_x[12*i +: 12] != PIPE_DISABLE)
                             & pipe_x_hit[i] & ~gap_y_hit[i];
    end

    assign ground_hit = (Set_Y >= 12'(GROUND_Y));

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            bird_q   <= 1'b0;
            pipe_q   <= '0;
            ground_q <= 1'b0;
            dead_q   <= 1'b0;
            vde_q    <= 1'b0;
        end else begin
            bird_q   <= bird_x_hit & bird_y_hit;
            pipe_q   <= pipe_hit;
            ground_q <= ground_hit;
            dead_q   <= s_over;
            vde_q    <= RGB_VDE;
        end
    end

    // Blanking forces black so nothing leaks into the porch/sync regions.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            RGB_In <= '0;
        end else if (vde_q) begin
            RGB_In <= pick_colour(bird_q, |pipe_q, ground_q, dead_q);
        end else begin
            RGB_In <= '0;
        end
    end

endmodule

// File: tb/tb_scene_render.sv
// Scoreboarded bench for scene_render: each driven pixel queues its expected colour,
// which is compared when the pixel emerges two clocks later.
module tb_scene_render;
    import scene_render_pkg::*;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic [11:0] Set_X = '0;
    logic [11:0] Set_Y = '0;
    logic        RGB_VDE = 1'b0;
    logic        RGB_VSync = 1'b0;
    logic [11:0] Bird_Y = '0;
    logic [47:0] Pipe_X = '0;
    logic [47:0] Gap_Y = '0;
    logic        Game_Over = 1'b0;
    logic [23:0] RGB_In;
    logic        Frame_Tick;
    logic [15:0] Frame_Cnt;

    int passed = 0;
    int total  = 0;

    logic [23:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    scene_render dut (
        .clk        (clk),
        .Rst        (Rst),
        .Set_X      (Set_X),
        .Set_Y      (Set_Y),
        .RGB_VDE    (RGB_VDE),
        .RGB_VSync  (RGB_VSync),
        .Bird_Y     (Bird_Y),
        .Pipe_X     (Pipe_X),
        .Gap_Y      (Gap_Y),
        .Game_Over  (Game_Over),
        .RGB_In     (RGB_In),
        .Frame_Tick (Frame_Tick),
        .Frame_Cnt  (Frame_Cnt)
    );

    task automatic clear_queues();
        exp_q.delete();
        chk_q.delete();
        name_q.delete();
    endtask

    // One pixel clock: retire the pixel driven two cycles ago, then drive a new one.
    task automatic step(input logic [11:0] x, input logic [11:0] y, input logic vde,
                        input logic vs, input bit chk, input logic [23:0] expv,
                        input string name);
        logic [23:0] e;
        bit          c;
        string       n;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            n = name_q.pop_front();
            if (c) begin
                total++;
                if (RGB_In !== e)
                    $display("[TB] FAIL %s: RGB_In=%h expected %h", n, RGB_In, e);
                else
                    passed++;
            end
        end
        Set_X     = x;
        Set_Y     = y;
        RGB_VDE   = vde;
        RGB_VSync = vs;
        exp_q.push_back(expv);
        chk_q.push_back(chk);
        name_q.push_back(name);
    endtask

    task automatic px(input logic [11:0] x, input logic [11:0] y,
                      input logic [23:0] expv, input string name);
        step(x, y, 1'b1, 1'b0, 1'b1, expv, name);
    endtask

    task automatic drain();
        repeat (2) step('0, '0, 1'b0, 1'b0, 1'b0, '0, "idle");
    endtask

    task automatic vsync_edge();
        step('0, '0, 1'b0, 1'b1, 1'b0, '0, "vsync");
        #1;
        total++;
        if (Frame_Tick !== 1'b1)
            $display("[TB] FAIL frame_tick_on_edge: Frame_Tick=%b expected 1", Frame_Tick);
        else
            passed++;
        step('0, '0, 1'b0, 1'b0, 1'b0, '0, "vsync_low");
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst       = 1'b0;
        RGB_VSync = 1'b0;
        RGB_VDE   = 1'b0;
        clear_queues();
        repeat (2) @(negedge clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Bird_Y    = 12'd400;
        Pipe_X    = {4{12'd600}};
        Gap_Y     = '0;
        Game_Over = 1'b1;
        @(negedge clk);
        Rst       = 1'b0;
        RGB_VSync = 1'b1;
        RGB_VDE   = 1'b1;
        Set_X     = 12'd200;
        Set_Y     = 12'd0;
        clear_queues();
        repeat (3) @(negedge clk);
        total++;
        if (RGB_In !== 24'h0) $display("[TB] FAIL reset_rgb: RGB_In=%h expected 000000", RGB_In);
        else passed++;
        total++;
        if (Frame_Tick !== 1'b0) $display("[TB] FAIL reset_tick: Frame_Tick=%b expected 0", Frame_Tick);
        else passed++;
        total++;
        if (Frame_Cnt !== 16'h0) $display("[TB] FAIL reset_cnt: Frame_Cnt=%h expected 0000", Frame_Cnt);
        else passed++;
        RGB_VSync = 1'b0;
        @(negedge clk);
        Rst = 1'b1;
        px(12'd200, 12'd0,   COL_BIRD,   "rst_bird_row0");
        px(12'd233, 12'd23,  COL_BIRD,   "rst_bird_corner");
        px(12'd200, 12'd24,  COL_SKY,    "rst_below_bird");
        px(12'd600, 12'd100, COL_SKY,    "rst_pipes_disabled");
        px(12'd10,  12'd800, COL_GROUND, "rst_ground");
        drain();
    endtask

    task automatic test_bird();
        Bird_Y    = 12'd400;
        Pipe_X    = {4{PIPE_DISABLE}};
        Gap_Y     = '0;
        Game_Over = 1'b0;
        vsync_edge();
        px(12'd200, 12'd400, COL_BIRD, "bird_top_left");
        px(12'd233, 12'd423, COL_BIRD, "bird_bottom_right");
        px(12'd234, 12'd400, COL_SKY,  "bird_right_edge");
        px(12'd200, 12'd424, COL_SKY,  "bird_bottom_edge");
        px(12'd199, 12'd400, COL_SKY,  "bird_left_edge");
        drain();
    endtask

    task automatic test_pipe();
        Pipe_X = {PIPE_DISABLE, PIPE_DISABLE, PIPE_DISABLE, 12'd600};
        Gap_Y  = {36'h0, 12'd300};
        vsync_edge();
        px(12'd600, 12'd299, COL_PIPE, "pipe_above_gap");
        px(12'd600, 12'd300, COL_SKY,  "pipe_gap_top");
        px(12'd600, 12'd499, COL_SKY,  "pipe_gap_bottom");
        px(12'd600, 12'd500, COL_PIPE, "pipe_below_gap");
        px(12'd651, 12'd100, COL_PIPE, "pipe_last_col");
        px(12'd652, 12'd100, COL_SKY,  "pipe_past_right");
        drain();
    endtask

    task automatic test_shadow();
        Bird_Y = 12'd500;
        px(12'd200, 12'd400, COL_BIRD, "shadow_old_row");
        px(12'd200, 12'd500, COL_SKY,  "shadow_new_row_early");
        step(12'd200, 12'd400, 1'b1, 1'b1, 1'b1, COL_BIRD, "shadow_edge_cycle_old");
        step(12'd200, 12'd500, 1'b1, 1'b0, 1'b1, COL_BIRD, "shadow_new_row_after");
        px(12'd200, 12'd400, COL_SKY, "shadow_old_row_gone");
        drain();
    endtask

    task automatic test_game_over();
        Bird_Y    = 12'd840;
        Pipe_X    = {PIPE_DISABLE, PIPE_DISABLE, 12'd200, 12'd200};
        Gap_Y     = {24'h0, 12'd100, 12'd100};
        Game_Over = 1'b1;
        vsync_edge();
        px(12'd210, 12'd850, COL_BIRD_DEAD, "dead_bird_over_pipe");
        px(12'd240, 12'd870, COL_PIPE,      "pipe_over_ground");
        px(12'd400, 12'd850, COL_GROUND,    "ground_only");
        px(12'd210, 12'd500, COL_PIPE,      "overlapping_pipes");
        px(12'd210, 12'd150, COL_SKY,       "overlapping_gap");
        drain();
    endtask

    task automatic test_vde();
        step(12'd210, 12'd850, 1'b0, 1'b0, 1'b1, 24'h0, "vde_low_in_bird");
        px(12'd210, 12'd850, COL_BIRD_DEAD, "vde_back_high");
        drain();
    endtask

    task automatic test_clip_and_reset_pulse();
        Bird_Y    = 12'd400;
        Pipe_X    = {PIPE_DISABLE, PIPE_DISABLE, PIPE_DISABLE, 12'd4080};
        Gap_Y     = {36'h0, 12'd4000};
        Game_Over = 1'b0;
        vsync_edge();
        px(12'd4085, 12'd100,  COL_PIPE,   "clip_pipe_right");
        px(12'd4095, 12'd4050, COL_GROUND, "clip_gap_region");
        px(12'd0,    12'd100,  COL_SKY,    "no_wrap_x0");
        px(12'd10,   12'd100,  COL_SKY,    "no_wrap_x10");
        px(12'd51,   12'd100,  COL_SKY,    "no_wrap_x51");
        px(12'd4090, 12'd100,  COL_PIPE,   "clip_pipe_mid");
        step(12'd4090, 12'd100, 1'b1, 1'b0, 1'b0, '0, "pre_pulse");
        #2;
        Rst = 1'b0;
        #1;
        total++;
        if (RGB_In !== 24'h0) $display("[TB] FAIL midline_reset: RGB_In=%h expected 000000", RGB_In);
        else passed++;
        clear_queues();
        @(negedge clk);
        Rst = 1'b1;
    endtask

    task automatic test_frame_cnt();
        int ticks;
        ticks = 0;
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            RGB_VSync = 1'b1;
            #1;
            if (Frame_Tick === 1'b1) ticks++;
            @(negedge clk);
            RGB_VSync = 1'b0;
            if (i == 0 || i == 65534) begin
                total++;
                if (Frame_Cnt !== 16'(i + 1))
                    $display("[TB] FAIL frame_cnt_step%0d: Frame_Cnt=%h expected %h", i, Frame_Cnt, 16'(i + 1));
                else
                    passed++;
            end
        end
        total++;
        if (Frame_Cnt !== 16'h0) $display("[TB] FAIL frame_cnt_wrap: Frame_Cnt=%h expected 0000", Frame_Cnt);
        else passed++;
        total++;
        if (ticks != 65536) $display("[TB] FAIL frame_tick_count: ticks=%0d expected 65536", ticks);
        else passed++;
        ticks = 0;
        @(negedge clk);
        RGB_VSync = 1'b1;
        repeat (6) begin
            #1;
            if (Frame_Tick === 1'b1) ticks++;
            @(negedge clk);
        end
        RGB_VSync = 1'b0;
        total++;
        if (ticks != 1) $display("[TB] FAIL vsync_held_ticks: ticks=%0d expected 1", ticks);
        else passed++;
        total++;
        if (Frame_Cnt !== 16'h1) $display("[TB] FAIL vsync_held_cnt: Frame_Cnt=%h expected 0001", Frame_Cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_bird();
        test_pipe();
        test_shadow();
        test_game_over();
        test_vde();
        test_clip_and_reset_pulse();
        test_frame_cnt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scene_render.md
SCENE_RENDER -- requirements
Module: scene_render

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  BIRD_X  200  bird left edge, pixels
  BIRD_W  34  bird width
  BIRD_H  24  bird height
  PIPE_W  52  pipe width
  GAP_H  200  vertical opening height of each pipe
  GROUND_Y  800  first ground row
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  pixel clock
  Rst  in  1  asynchronous, active-low reset
  Set_X  in  12  current pixel X from the timing driver
  Set_Y  in  12  current pixel Y from the timing driver
  RGB_VDE  in  1  data-valid from the timing driver
  RGB_VSync  in  1  field sync from the timing driver, active high
  Bird_Y  in  12  bird top row from game logic
  Pipe_X  in  48  four 12-bit pipe left edges; pipe i uses bits [12i+11:12i]; 12'hFFF disables the pipe
  Gap_Y  in  48  four 12-bit gap top rows, packed the same way
  Game_Over  in  1  game-over flag from game logic
  RGB_In  out  24  pixel colour to the timing driver, {R,G,B}
  Frame_Tick  out  1  one-cycle pulse per frame
  Frame_Cnt  out  16  frame counter, wraps to 0

Function
REQ-003 VSync_d (registered RGB_VSync) SHALL detect the rising edge; on that edge the cycle (edge cycle) SHALL latch Bird_Y, Pipe_X, Gap_Y and Game_Over into shadow registers.
REQ-004 The latch SHALL take effect on the cycle after the edge cycle; shadow values SHALL stay constant for the whole frame.
REQ-005 Frame_Tick SHALL be high for exactly the edge cycle, and Frame_Cnt SHALL increment by 1 on the same edge; 16'hFFFF SHALL wrap to 0.
REQ-006 The pixel path SHALL be a two-stage pipeline.
  Stage 1 registers the hit flags bird_hit, pipe_hit[3:0] and ground_hit, plus VDE.
  Stage 2 registers the priority-muxed colour onto RGB_In.
  Latency from Set_X/Set_Y/RGB_VDE to RGB_In is exactly 2 clocks.
REQ-007 Hit tests:
  bird_hit = Set_X in [BIRD_X, BIRD_X+BIRD_W) and Set_Y in [sBird_Y, sBird_Y+BIRD_H).
  pipe_hit[i] = pipe enabled and Set_X in [sPipe_X[i], sPipe_X[i]+PIPE_W) and Set_Y outside [sGap_Y[i], sGap_Y[i]+GAP_H).
  ground_hit = Set_Y >= GROUND_Y.
REQ-008 All bound sums SHALL be computed at 13 bits so they never wrap; a box extending past 4095 is clipped, not wrapped.
REQ-009 Colour priority: bird, then any pipe, then ground, then sky.
  Bird colour is COL_BIRD, or COL_BIRD_DEAD when shadow Game_Over=1.
  Pipe colour is COL_PIPE, ground is COL_GROUND, sky is COL_SKY.
REQ-010 When the stage-1 VDE is 0, RGB_In SHALL be 24'h000000.
REQ-011 When several pipes overlap a pixel, the output SHALL be COL_PIPE, with no per-pipe distinction.
REQ-012 If RGB_VSync is held high, only one Frame_Tick SHALL occur, at its rising edge.

Reset
REQ-013 While Rst=0, all of the following SHALL be 0:
  RGB_In, Frame_Tick, Frame_Cnt, VSync_d, pipeline registers, all shadow registers.
REQ-014 While Rst=0, shadow Pipe_X SHALL be 12'hFFF (all pipes disabled).
REQ-015 After reset, the first latch SHALL occur at the first VSync rising edge; pixels before it render with the reset shadow values, i.e. sky, ground and the bird at row 0.
REQ-016 Reset asserted mid-frame SHALL clear the pipeline immediately, and RGB_In SHALL be 0 on the next observation.

Structure
REQ-017 A shared package SHALL hold:
  COL_SKY = 24'h70C5CE, COL_PIPE = 24'h5EBD3B, COL_GROUND = 24'hDED895, COL_BIRD = 24'hF8E71C, COL_BIRD_DEAD = 24'hE03020
  PIPE_DISABLE = 12'hFFF, NUM_PIPES = 4
REQ-018 One sub-module, span_hit, SHALL implement the 13-bit "coordinate in [base, base+len)" comparator and SHALL be instantiated for every X and Y test.

Verification
REQ-019 Reset, then VSync rising edge with Bird_Y=400 -> in the following frame, (200,400) and (233,423) output COL_BIRD; (234,400) and (200,424) do not, each observed 2 clocks after the coordinate.
REQ-020 Pipe_X[11:0]=600, Gap_Y[11:0]=300, other pipes 12'hFFF -> (600,299)=COL_PIPE, (600,300)=COL_SKY, (600,500)=COL_PIPE, (652,100)=COL_SKY.
REQ-021 Change Bird_Y from 400 to 500 mid-frame -> bird remains at row 400 until the next VSync edge, then renders at row 500.
REQ-022 Bird overlapping a pipe at Y=850 with Game_Over=1 latched -> COL_BIRD_DEAD; outside the bird box, Y=850 shows COL_PIPE, and with no pipe shows COL_GROUND.
REQ-023 RGB_VDE=0 with coordinates inside the bird box -> RGB_In=0; 65536 VSync edges -> Frame_Cnt returns to 0 and exactly 65536 Frame_Tick pulses are counted.
REQ-024 Pipe_X=4080, Gap_Y=4000 -> no wrap hits at X<52, and RGB_In is 0 while Rst is pulsed low mid-line.
